// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that reuses one 4-bit ripple slice,
// processing one nibble per clock from the least-significant nibble up.
// Ports: clk, reset_n (async, active-low), start, a, b, ci in;
//        busy, done, s (registered sum), co (registered carry) out.

module rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[4];
    end
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);
    localparam int N  = WIDTH / 4;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;

    logic [3:0]       nib_sum;
    logic             nib_co;
    logic [WIDTH-1:0] s_next;

    rca4 u_slice (
        .a  (a_sh_q[3:0]),
        .b  (b_sh_q[3:0]),
        .ci (carry_q),
        .s  (nib_sum),
        .co (nib_co)
    );

    // New nibble enters at the top so the first nibble ends up at the bottom.
    assign s_next = {nib_sum, s_sh_q[WIDTH-1:4]};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        co_d    = co_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = ci;
                    s_sh_d  = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d  = {4'h0, a_sh_q[WIDTH-1:4]};
                b_sh_d  = {4'h0, b_sh_q[WIDTH-1:4]};
                s_sh_d  = s_next;
                carry_d = nib_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    s_d     = s_next;
                    co_d    = nib_co;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            co_q    <= co_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign co   = co_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=32, N=8).
// Drives vectors with hand-computed sums and checks handshake timing.

module tb_nibble_serial_adder;
    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] a, b;
    logic        ci;
    logic        busy, done, co;
    logic [31:0] s;

    int checks;
    int errors;

    nibble_serial_adder #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .ci      (ci),
        .busy    (busy),
        .done    (done),
        .s       (s),
        .co      (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one op, check busy/done timing, hold of old s, then result.
    task automatic run_op(input string tag, input logic [31:0] ta,
                          input logic [31:0] tb, input logic tci,
                          input logic [31:0] prev_s, input logic prev_co,
                          input logic [31:0] exp_s, input logic exp_co);
        a = ta; b = tb; ci = tci; start = 1'b1;
        tick();
        start = 1'b0;
        a = $urandom; b = $urandom; ci = 1'b1;
        check({tag, " busy@accept"}, 64'(busy), 64'd1);
        for (int i = 1; i < 8; i++) begin
            tick();
            check({tag, " busy run"}, 64'(busy), 64'd1);
            check({tag, " done run"}, 64'(done), 64'd0);
            check({tag, " s hold"}, 64'({prev_co, prev_s}),
                  64'({co, s}));
        end
        tick();
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " busy@done"}, 64'(busy), 64'd0);
        check({tag, " s"}, 64'(s), 64'(exp_s));
        check({tag, " co"}, 64'(co), 64'(exp_co));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        start = 1'b0;
        a = '0; b = '0; ci = 1'b0;

        // Reset held with start toggling
        for (int i = 0; i < 4; i++) begin
            start = ~start;
            a = 32'hFFFF_FFFF; b = 32'h1;
            tick();
        end
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst s", 64'(s), 64'd0);
        check("rst co", 64'(co), 64'd0);
        start = 1'b0;
        reset_n = 1'b1;
        tick();
        tick();
        check("idle busy", 64'(busy), 64'd0);
        check("idle done", 64'(done), 64'd0);

        run_op("basic", 32'h1, 32'h1, 1'b0, 32'h0, 1'b0, 32'h2, 1'b0);
        tick();
        check("basic done drop", 64'(done), 64'd0);
        check("basic s keep", 64'(s), 64'h2);
        tick();
        check("basic s keep2", 64'(s), 64'h2);

        run_op("fullprop", 32'hFFFF_FFFF, 32'h0, 1'b1,
               32'h2, 1'b0, 32'h0, 1'b1);
        tick();
        run_op("msb", 32'h8000_0000, 32'h8000_0000, 1'b0,
               32'h0, 1'b1, 32'h0, 1'b1);
        tick();
        run_op("mixed", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0,
               32'h0, 1'b1, 32'hACF1_3568, 1'b0);
        tick();

        // Start while busy is ignored
        a = 32'h3; b = 32'h4; ci = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 32'hFFFF_FFFF; b = 32'h1; ci = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check("coll busy", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("coll no early done", 64'(done), 64'd0);
        end
        tick();
        check("coll done", 64'(done), 64'd1);
        check("coll s", 64'(s), 64'h7);
        check("coll co", 64'(co), 64'd0);

        // Relaunch in the DONE cycle
        run_op("b2b", 32'hF, 32'h1, 1'b0, 32'h7, 1'b0, 32'h10, 1'b0);
        tick();
        check("b2b idle", 64'(busy), 64'd0);

        // Asynchronous reset mid-run
        a = 32'hFFFF_FFFF; b = 32'h1; ci = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("mid rst busy", 64'(busy), 64'd0);
        check("mid rst done", 64'(done), 64'd0);
        check("mid rst s", 64'(s), 64'd0);
        check("mid rst co", 64'(co), 64'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("mid rst no done", 64'(done), 64'd0);
        end
        reset_n = 1'b1;
        tick();
        check("post rst idle", 64'(busy), 64'd0);
        run_op("post rst", 32'h5, 32'h6, 1'b0, 32'h0, 1'b0, 32'hB, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
